uart_mem_sender: RTL and testbench

- Reads a block of bytes from the sample memory, starting at address 0, and serializes them on the RS232 TX line as 8N1, LSB first.
- It is the read side of the sample memory and the transmit end of the serial link.
- It produces the `iSendingDone` pulse that the top-level FSM consumes to return to IDLE.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_mem_sender_if.sv | 11 +
 rtl/baud_tick_gen.sv | 28 ++
 rtl/uart_mem_sender.sv | 137 +++++++++++++
 tb/tb_uart_mem_sender.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and baud math.
// The receiver imports this too, so both ends derive CLKS_PER_BIT identically.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LOAD      = 3'd2,
        S_START_BIT = 3'd3,
        S_DATA_BITS = 3'd4,
        S_STOP_BIT  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Integer division; the caller must keep the result >= 2.
    function automatic int clksPerBit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/uart_mem_sender_if.sv
// Sample-memory read port: address + read strobe out, data back one cycle later.
interface uart_mem_sender_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] oMemAddr;
    logic                  oMemRead;
    logic [7:0]            iMemData;

    modport master (output oMemAddr, output oMemRead, input iMemData);
    modport slave  (input oMemAddr, input oMemRead, output iMemData);
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Holding iRestart keeps the count at 0, so every bit starts with a fresh phase.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic iClock,
    input  logic iReset,
    input  logic iRestart,
    output logic oTick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Free-running bit counter, wrapping on the terminal count.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            count <= '0;
        end else if (iRestart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign oTick = !iRestart && (count == LAST);
endmodule

// File: rtl/uart_mem_sender.sv
// Reads iLength bytes from sample memory starting at address 0 and sends them
// 8N1, LSB first, then pulses oSendingDone for the top-level sequencer.
//
// state       | meaning
// ------------+---------------------------------------------------
// IDLE        | line high, waiting for iStart
// FETCH       | read strobe issued for current address
// LOAD        | memory data captured into shift register
// START_BIT   | line low for one bit period
// DATA_BITS   | shift register bit 0 on line, 8 bit periods
// STOP_BIT    | line high for one bit period, then next byte or done
// DONE        | one-cycle completion pulse
module uart_mem_sender
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD),
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH:0]   iLength,
    uart_mem_sender_if.master     memBus,
    output logic                  oTx,
    output logic                  oBusy,
    output logic                  oSendingDone
);
    state_t                state;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memRead;
    logic [7:0]            shiftReg;
    logic [2:0]            bitIdx;
    logic                  tick;
    logic                  restart;

    // Baud timer only runs while a bit is on the line.
    assign restart = !(state == S_START_BIT || state == S_DATA_BITS || state == S_STOP_BIT);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uBaud (
        .iClock  (iClock),
        .iReset  (iReset),
        .iRestart(restart),
        .oTick   (tick)
    );

    assign memBus.oMemAddr = memAddr;
    assign memBus.oMemRead = memRead;

    // Sequencer; every output is set together with the state it belongs to.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            memAddr      <= '0;
            memRead      <= 1'b0;
            shiftReg     <= '0;
            bitIdx       <= '0;
            oTx          <= LINE_IDLE;
            oBusy        <= 1'b0;
            oSendingDone <= 1'b0;
        end else begin
            memRead      <= 1'b0;
            oSendingDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    oTx <= LINE_IDLE;
                    if (iStart) begin
                        remaining <= iLength;
                        memAddr   <= '0;
                        oBusy     <= 1'b1;
                        if (iLength == '0) begin
                            state        <= S_DONE;
                            oSendingDone <= 1'b1;
                        end else begin
                            state   <= S_FETCH;
                            memRead <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shiftReg <= memBus.iMemData;
                    oTx      <= LINE_START;
                    state    <= S_START_BIT;
                end
                S_START_BIT: begin
                    if (tick) begin
                        bitIdx <= '0;
                        oTx    <= shiftReg[0];
                        state  <= S_DATA_BITS;
                    end
                end
                S_DATA_BITS: begin
                    if (tick) begin
                        if (bitIdx == 3'd7) begin
                            oTx   <= LINE_STOP;
                            state <= S_STOP_BIT;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            shiftReg <= shiftReg >> 1;
                            oTx      <= shiftReg[1];
                        end
                    end
                end
                S_STOP_BIT: begin
                    if (tick) begin
                        remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                        memAddr   <= memAddr + ADDR_WIDTH'(1);
                        if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                            state        <= S_DONE;
                            oSendingDone <= 1'b1;
                        end else begin
                            state   <= S_FETCH;
                            memRead <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    oBusy <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    oTx   <= LINE_IDLE;
                    oBusy <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_sender.sv
// Directed bench for uart_mem_sender at CLKS_PER_BIT=4, ADDR_WIDTH=2.
// Cycle 0 is the cycle in which iStart is high; outputs are sampled on negedges.
module tb_uart_mem_sender;
    localparam int AW   = 2;
    localparam int MAXC = 400;

    logic          clk    = 1'b0;
    logic          rstN   = 1'b0;
    logic          start  = 1'b0;
    logic [AW:0]   length = '0;
    logic          tx;
    logic          busy;
    logic          done;

    uart_mem_sender_if #(.ADDR_WIDTH(AW)) memBus ();

    uart_mem_sender #(
        .CLK_FREQ  (1000),
        .BAUD      (250),
        .ADDR_WIDTH(AW)
    ) dut (
        .iClock      (clk),
        .iReset      (rstN),
        .iStart      (start),
        .iLength     (length),
        .memBus      (memBus.master),
        .oTx         (tx),
        .oBusy       (busy),
        .oSendingDone(done)
    );

    always #5 clk = ~clk;

    // Sample memory: registered read, data valid the cycle after the strobe.
    logic [7:0] mem [4];
    always @(posedge clk) begin
        if (memBus.oMemRead) memBus.iMemData <= mem[memBus.oMemAddr];
    end

    typedef struct packed {
        int          len;
        logic [31:0] memWord;
        int          nExp;
        logic [31:0] expWord;
        int          doneCycle;
        int          finalAddr;
    } vec_t;

    vec_t vecs [5];

    logic txLog   [MAXC];
    logic busyLog [MAXC];
    int   readAddr [$];
    int   readCycle [$];
    int   gotBytes [$];
    int   startCycles [$];
    int   doneCnt, doneCycle, nCyc;
    logic timedOut;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic loadMem(input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[i] = w[8*i +: 8];
    endtask

    // Runs one transfer, logging line/busy per cycle until done has pulsed and busy dropped.
    // A second iStart with injLen can be injected in cycle injCycle. iLength is
    // deliberately perturbed after acceptance.
    task automatic runTransfer(input int len, input int injCycle, input int injLen);
        readAddr.delete();
        readCycle.delete();
        doneCnt  = 0;
        doneCycle = -1;
        timedOut = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        length = len[AW:0];
        txLog[0]   = tx;
        busyLog[0] = busy;
        nCyc = 1;
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk);
            start  = (c == injCycle);
            length = (c == injCycle) ? injLen[AW:0] : len[AW:0] + 1'b1;
            txLog[c]   = tx;
            busyLog[c] = busy;
            if (memBus.oMemRead) begin
                readAddr.push_back(int'(memBus.oMemAddr));
                readCycle.push_back(c);
            end
            if (done) begin
                doneCnt++;
                doneCycle = c;
            end
            nCyc = c + 1;
            if (doneCnt > 0 && !busy) begin
                timedOut = 1'b0;
                break;
            end
        end
        start = 1'b0;
        check("transfer_timeout", int'(timedOut), 0);
    endtask

    // UART monitor over the logged line: start bit low, sample each bit mid-period.
    task automatic decodeLine();
        int i;
        gotBytes.delete();
        startCycles.delete();
        i = 1;
        while (i + 39 < nCyc) begin
            if (!txLog[i]) begin
                logic [7:0] b;
                for (int k = 0; k < 8; k++) b[k] = txLog[i + 4*(k+1) + 2];
                gotBytes.push_back(int'(b));
                startCycles.push_back(i);
                check("stop_bit", int'(txLog[i + 38]), 1);
                i += 40;
            end else begin
                i++;
            end
        end
    endtask

    task automatic checkStaysIdle(input string name, input int ncycles);
        int bad;
        bad = 0;
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            if (busy || done || memBus.oMemRead || !tx) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        vecs[0] = '{len:1, memWord:32'h000000A5, nExp:1, expWord:32'h000000A5, doneCycle:43,  finalAddr:1};
        vecs[1] = '{len:3, memWord:32'hEE55FF00, nExp:3, expWord:32'h0055FF00, doneCycle:127, finalAddr:3};
        vecs[2] = '{len:4, memWord:32'h44332211, nExp:4, expWord:32'h44332211, doneCycle:169, finalAddr:0};
        vecs[3] = '{len:0, memWord:32'hDEADBEEF, nExp:0, expWord:32'h00000000, doneCycle:1,   finalAddr:0};
        vecs[4] = '{len:2, memWord:32'h0000C33C, nExp:2, expWord:32'h0000C33C, doneCycle:85,  finalAddr:2};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_tx",      int'(tx), 1);
        check("reset_busy",    int'(busy), 0);
        check("reset_done",    int'(done), 0);
        check("reset_memread", int'(memBus.oMemRead), 0);
        check("reset_memaddr", int'(memBus.oMemAddr), 0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven transfers
        for (int v = 0; v < 5; v++) begin
            loadMem(vecs[v].memWord);
            runTransfer(vecs[v].len, -1, 0);
            decodeLine();
            check("byte_count", gotBytes.size(), vecs[v].nExp);
            for (int b = 0; b < gotBytes.size() && b < vecs[v].nExp; b++)
                check("byte_value", gotBytes[b], int'(vecs[v].expWord[8*b +: 8]));
            check("read_count", readAddr.size(), vecs[v].len);
            for (int r = 0; r < readAddr.size(); r++)
                check("read_addr", readAddr[r], r % 4);
            check("done_count", doneCnt, 1);
            check("done_cycle", doneCycle, vecs[v].doneCycle);
            check("final_addr", int'(memBus.oMemAddr), vecs[v].finalAddr);
            if (startCycles.size() > 0) begin
                check("first_start_cycle", startCycles[0], 3);
                check("first_read_cycle", readCycle[0], 1);
            end
            for (int s = 1; s < startCycles.size(); s++)
                check("byte_spacing", startCycles[s] - startCycles[s-1], 42);
            if (vecs[v].len == 0) begin
                int lows;
                lows = 0;
                for (int c = 0; c < nCyc; c++) if (!txLog[c]) lows++;
                check("zero_len_line_high", lows, 0);
            end
        end

        // Exact single-byte waveform for 0xA5
        begin
            logic [9:0] pat;
            int bad;
            mem[0] = 8'hA5;
            runTransfer(1, -1, 0);
            pat = {1'b1, 8'hA5, 1'b0};
            bad = 0;
            for (int c = 3; c < 43; c++) if (txLog[c] !== pat[(c-3)/4]) bad++;
            check("a5_waveform", bad, 0);
            check("a5_high_fetch", int'(txLog[1]), 1);
            check("a5_high_load",  int'(txLog[2]), 1);
            check("a5_high_done",  int'(txLog[43]), 1);
            check("a5_busy_done",  int'(busyLog[43]), 1);
            check("a5_busy_after", int'(busyLog[44]), 0);
            check("a5_cycles",     nCyc, 45);
        end

        // iStart during DATA_BITS is dropped
        mem[0] = 8'hA5;
        runTransfer(1, 15, 5);
        decodeLine();
        check("busy_start_bytes", gotBytes.size(), 1);
        check("busy_start_reads", readAddr.size(), 1);
        check("busy_start_done",  doneCnt, 1);
        checkStaysIdle("busy_start_not_queued", 12);

        // iStart during DONE is dropped
        runTransfer(1, 43, 5);
        check("done_start_done", doneCnt, 1);
        checkStaysIdle("done_start_not_queued", 12);

        // Reset in the middle of data bit 3 (line low for 0xA5)
        begin
            int pulses;
            mem[0] = 8'hA5;
            mem[1] = 8'h77;
            @(negedge clk);
            start  = 1'b1;
            length = 3'd2;
            @(negedge clk);
            start = 1'b0;
            repeat (19) @(negedge clk);
            check("pre_reset_tx", int'(tx), 0);
            #1 rstN = 1'b0;
            #1;
            check("async_reset_tx",   int'(tx), 1);
            check("async_reset_busy", int'(busy), 0);
            pulses = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) pulses++;
            end
            rstN = 1'b1;
            repeat (60) begin
                @(negedge clk);
                if (done || busy) pulses++;
            end
            check("reset_no_done", pulses, 0);
            mem[0] = 8'h5A;
            runTransfer(1, -1, 0);
            decodeLine();
            check("post_reset_bytes", gotBytes.size(), 1);
            if (gotBytes.size() > 0) check("post_reset_value", gotBytes[0], 8'h5A);
            if (readAddr.size() > 0) check("post_reset_addr", readAddr[0], 0);
            check("post_reset_done", doneCnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
